// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle for the FIFO write arbiter.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BITSIZE = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*BITSIZE-1:0] req_data;
    logic                       full;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         ack;
    logic                       w_enable;
    logic [BITSIZE-1:0]         wdata;
    logic [15:0]                stall_cnt;

    // Requesters and FIFO flag side
    modport master (
        output req, req_data, full,
        input  grant, ack, w_enable, wdata, stall_cnt
    );

    // Arbiter side
    modport slave (
        input  req, req_data, full,
        output grant, ack, w_enable, wdata, stall_cnt
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that funnels NUM_REQ writers into one FIFO write port.
module fifo_write_arbiter #(
    parameter int unsigned BITSIZE   = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned STALL_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic               owner_req_c;
    logic               xfer_c;
    logic               stall_c;
    logic               release_c;
    logic               others_c;
    logic [NUM_REQ-1:0] owner_oh_c;
    logic [BITSIZE-1:0] owner_data_c;

    // First set request bit at or after 'start', wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input int unsigned start);
        logic [IDX_W-1:0] sel;
        logic             found;
        int unsigned      idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (!found && r[IDX_W'(idx)]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Owner data mux.
    always_comb begin
        owner_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_data_c = bus.req_data[i*BITSIZE +: BITSIZE];
            end
        end
    end

    // Transfer/stall/release qualifiers for the current owner.
    always_comb begin
        owner_oh_c  = NUM_REQ'(1) << owner_q;
        owner_req_c = bus.req[owner_q];
        xfer_c      = (state_q == GRANT) && owner_req_c && !bus.full;
        stall_c     = (state_q == GRANT) && owner_req_c && bus.full;
        release_c   = (xfer_c && (beat_q == BEAT_W'(MAX_BURST - 1)))
                    || ((state_q == GRANT) && !owner_req_c);
        others_c    = |(bus.req & ~owner_oh_c);
    end

    // Next-state: round-robin grant, burst counting, release and re-grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        grant_d = '0;
        stall_d = stall_q;

        if (stall_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    owner_d = rr_pick(bus.req, 32'(last_q) + 32'd1);
                end
            end
            GRANT: begin
                if (xfer_c) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (release_c) begin
                    last_d = owner_q;
                    beat_d = '0;
                    if (others_c) begin
                        owner_d = rr_pick(bus.req, 32'(owner_q) + 32'd1);
                    end else if (!owner_req_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GRANT) begin
            grant_d = NUM_REQ'(1) << owner_d;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
            grant_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            stall_q <= stall_d;
        end
    end

    // Write strobe and ack follow the live transfer condition; state is forced
    // to IDLE asynchronously, so an in-flight write drops as soon as reset lands.
    assign bus.grant     = grant_q;
    assign bus.w_enable  = xfer_c;
    assign bus.ack       = xfer_c ? owner_oh_c : '0;
    assign bus.wdata     = reset ? owner_data_c : '0;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a per-cycle behavioural model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
    localparam int unsigned BITSIZE   = 8;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .BITSIZE(BITSIZE)) bus ();

    fifo_write_arbiter #(
        .BITSIZE  (BITSIZE),
        .NUM_REQ  (NUM_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Requester stimulus: words still to send and sequence number per requester.
    int                 remaining [NUM_REQ];
    int                 seq       [NUM_REQ];
    logic               full_drv;
    logic [NUM_REQ-1:0] pend_ack;

    int checks = 0;
    int passes = 0;

    // Model of the arbiter, expressed as "who owns the port and for how many beats".
    bit m_active;
    int m_held;
    int m_last;
    int m_beats;
    int m_stall;

    function automatic logic [BITSIZE-1:0] word(input int i, input int s);
        return BITSIZE'((i << 6) | (s & 63));
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int from);
        for (int n = 0; n < NUM_REQ; n++) begin
            if (r[(from + n) % NUM_REQ]) return (from + n) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive();
        logic [NUM_REQ-1:0]         r;
        logic [NUM_REQ*BITSIZE-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            r[i] = (remaining[i] > 0);
            d[i*BITSIZE +: BITSIZE] = word(i, seq[i]);
        end
        bus.req      = r;
        bus.req_data = d;
        bus.full     = full_drv;
    endtask

    // Advance one clock; requesters whose word was accepted move to the next word.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_ack[i]) begin
                remaining[i]--;
                seq[i]++;
            end
        end
        pend_ack = '0;
        drive();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        full_drv = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        pend_ack = '0;
        drive();
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] r;
        logic [NUM_REQ-1:0] e_grant;
        logic [NUM_REQ-1:0] e_ack;
        logic               e_we;
        logic [BITSIZE-1:0] e_wdata;
        r = bus.req;
        if (!reset) begin
            m_active = 1'b0;
            m_held   = 0;
            m_last   = NUM_REQ - 1;
            m_beats  = 0;
            m_stall  = 0;
            e_grant  = '0;
            e_ack    = '0;
            e_we     = 1'b0;
            e_wdata  = '0;
        end else begin
            e_grant = m_active ? NUM_REQ'(1 << m_held) : '0;
            e_we    = m_active && r[m_held] && !bus.full;
            e_ack   = e_we ? NUM_REQ'(1 << m_held) : '0;
            e_wdata = bus.req_data[m_held*BITSIZE +: BITSIZE];
        end
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("ack", 32'(bus.ack), 32'(e_ack));
        chk("w_enable", 32'(bus.w_enable), 32'(e_we));
        chk("wdata", 32'(bus.wdata), 32'(e_wdata));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        if (reset) begin
            pend_ack = e_ack;
            if (m_active && r[m_held] && bus.full && m_stall < 65535) m_stall++;
            if (!m_active) begin
                if (r != '0) begin
                    m_held   = pick(r, (m_last + 1) % NUM_REQ);
                    m_active = 1'b1;
                end
            end else begin
                if (e_we) m_beats++;
                if ((e_we && m_beats == MAX_BURST) || !r[m_held]) begin
                    m_last  = m_held;
                    m_beats = 0;
                    if ((r & ~e_grant) != '0) m_held = pick(r, m_held + 1);
                    else if (!r[m_held]) m_active = 1'b0;
                end
            end
        end
    end

    int writes;

    initial begin
        reset    = 1'b0;
        full_drv = 1'b0;
        pend_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
            seq[i]       = 1;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'h0);
        chk("rst_wdata", 32'(bus.wdata), 32'h0);
        reset = 1'b1;

        // Single requester, 6 words: burst of 4, re-grant, 2 more, then idle.
        remaining[0] = 6;
        drive();
        step(); #2;
        chk("t1_first_grant", 32'(bus.grant), 32'h1);
        chk("t1_first_write", 32'(bus.w_enable), 32'h1);
        chk("t1_wdata", 32'(bus.wdata), 32'h01);
        writes = 1;
        repeat (7) begin
            step(); #2;
            if (bus.w_enable) writes++;
        end
        chk("t1_writes", 32'(writes), 32'd6);
        chk("t1_idle_grant", 32'(bus.grant), 32'h0);

        // All four requesting: grants rotate every 4 beats with no bubbles.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 8;
        drive();
        writes = 0;
        for (int k = 1; k <= 32; k++) begin
            step(); #2;
            if (bus.w_enable) writes++;
            if (((k - 1) % 4 == 0) && (k <= 17))
                chk("t2_grant", 32'(bus.grant), 32'(1 << (((k - 1) / 4) % 4)));
            if (k == 5) chk("t2_wdata_r1", 32'(bus.wdata), 32'h41);
        end
        chk("t2_writes", 32'(writes), 32'd32);
        repeat (3) step();

        // Backpressure: full for 5 cycles inside requester 2's burst.
        do_reset();
        remaining[2] = 4;
        drive();
        step(); #2;
        chk("t3_grant", 32'(bus.grant), 32'h4);
        step();
        full_drv = 1'b1;
        drive();
        repeat (5) begin
            #2;
            chk("t3_stall_we", 32'(bus.w_enable), 32'h0);
            chk("t3_stall_grant", 32'(bus.grant), 32'h4);
            step();
        end
        full_drv = 1'b0;
        drive();
        #2;
        chk("t3_stall_cnt", 32'(bus.stall_cnt), 32'd5);
        chk("t3_resume_we", 32'(bus.w_enable), 32'h1);
        repeat (6) step();

        // Early drop: requester 1 leaves after 2 beats, requester 3 takes over.
        do_reset();
        remaining[1] = 10;
        remaining[3] = 5;
        drive();
        step(); #2;
        chk("t4_grant1", 32'(bus.grant), 32'h2);
        step();
        step();
        remaining[1] = 0;
        remaining[0] = 2;
        drive();
        #2;
        chk("t4_drop_we", 32'(bus.w_enable), 32'h0);
        step(); #2;
        chk("t4_grant3", 32'(bus.grant), 32'h8);
        chk("t4_ack3", 32'(bus.ack), 32'h8);
        repeat (3) step();
        #2;
        chk("t4_full_burst", 32'(bus.grant), 32'h8);
        step(); #2;
        chk("t4_next_owner", 32'(bus.grant), 32'h1);
        repeat (10) step();

        // Reset in the middle of a burst, then everybody requests.
        do_reset();
        remaining[0] = 8;
        drive();
        step(); #2;
        chk("t5_we1", 32'(bus.w_enable), 32'h1);
        step(); #2;
        chk("t5_we2", 32'(bus.w_enable), 32'h1);
        reset = 1'b0;
        #1;
        chk("t5_async_we", 32'(bus.w_enable), 32'h0);
        chk("t5_async_ack", 32'(bus.ack), 32'h0);
        chk("t5_async_grant", 32'(bus.grant), 32'h0);
        step();
        step();
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 4;
        reset = 1'b1;
        drive();
        step(); #2;
        chk("t5_first_owner", 32'(bus.grant), 32'h1);
        repeat (20) step();

        // Long full: stall counter saturates and does not wrap.
        do_reset();
        remaining[1] = 1;
        full_drv = 1'b1;
        drive();
        step(); #2;
        chk("t6_grant", 32'(bus.grant), 32'h2);
        repeat (70000) step();
        #2;
        chk("t6_sat", 32'(bus.stall_cnt), 32'hFFFF);
        chk("t6_we", 32'(bus.w_enable), 32'h0);
        full_drv = 1'b0;
        drive();
        #1;
        chk("t6_release_we", 32'(bus.w_enable), 32'h1);
        chk("t6_sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
